uart2apb_burst_ctrl: RTL and testbench

- Byte-stream frame decoder and APB3 master that sits between the UART core's RX/TX FIFO byte ports and the on-chip APB configuration bus.
- Successor to the fixed 16/32-bit single-access controller: address and data widths are parameterised, bursts carry 1..MAX_BURST beats with optional address auto-increment, and the block adds PSLVERR reporting, a PREADY timeout, an RX inter-byte timeout and a two-byte status trailer on every frame.

---
 rtl/uart2apb_burst_ctrl_if.sv | 36 +++
 rtl/uart2apb_burst_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_uart2apb_burst_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart2apb_burst_ctrl_if.sv
// UART byte-port and APB3 master signal bundle for uart2apb_burst_ctrl.
// master: the controller side; slave: the UART FIFOs plus the APB target.
interface uart2apb_burst_ctrl_if #(
   parameter int AW = 16,
   parameter int DW = 32
);
   localparam int NB = DW / 8;

   logic          i_rx_vld;
   logic [7:0]    i_rx_data;
   logic          o_rx_rdy;
   logic          o_tx_vld;
   logic [7:0]    o_tx_data;
   logic          i_tx_rdy;
   logic          o_p_sel;
   logic          o_p_enable;
   logic          o_p_we;
   logic [AW-1:0] o_p_addr;
   logic [DW-1:0] o_p_wdata;
   logic [NB-1:0] o_p_strb;
   logic          i_p_ready;
   logic [DW-1:0] i_p_rdata;
   logic          i_p_slverr;

   modport master (
      input  i_rx_vld, i_rx_data, i_tx_rdy, i_p_ready, i_p_rdata, i_p_slverr,
      output o_rx_rdy, o_tx_vld, o_tx_data,
      output o_p_sel, o_p_enable, o_p_we, o_p_addr, o_p_wdata, o_p_strb
   );

   modport slave (
      output i_rx_vld, i_rx_data, i_tx_rdy, i_p_ready, i_p_rdata, i_p_slverr,
      input  o_rx_rdy, o_tx_vld, o_tx_data,
      input  o_p_sel, o_p_enable, o_p_we, o_p_addr, o_p_wdata, o_p_strb
   );
endinterface

// File: rtl/uart2apb_burst_ctrl.sv
// UART byte-stream frame decoder driving an APB3 master with burst support,
// bus/RX timeouts and a two-byte status trailer on every frame.
module uart2apb_burst_ctrl #(
   parameter int AW          = 16,
   parameter int DW          = 32,
   parameter int MAX_BURST   = 16,
   parameter int RX_TO_CYC   = 100000,
   parameter int PRDY_TO_CYC = 255
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   uart2apb_burst_ctrl_if.master bus,
   output logic                  o_busy
);
   localparam int NB = DW / 8;
   localparam int AB = AW / 8;

   typedef enum logic [2:0] {
      S_RST, S_IDLE, S_ADDR, S_WDATA, S_SETUP, S_ACCESS, S_RDTX, S_STAT
   } state_t;

   state_t        state, state_nx;
   logic          cmd_we, cmd_inc;
   logic [4:0]    nbeats, done;
   logic [3:0]    bcnt, bcnt_lim;
   logic          bcnt_last;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata, rdata;
   logic [31:0]   rx_tmr, prdy_tmr;
   logic [7:0]    code, code_nx;
   logic          set_code, stat_hi;
   logic          cmd_bad, rx_fire, tx_fire;

   assign rx_fire   = bus.i_rx_vld & bus.o_rx_rdy;
   assign tx_fire   = bus.o_tx_vld & bus.i_tx_rdy;
   assign cmd_bad   = (bus.i_rx_data[5:4] != 2'b00) ||
                      (({1'b0, bus.i_rx_data[3:0]} + 5'd1) > 5'(MAX_BURST));
   assign bcnt_lim  = (state == S_ADDR) ? 4'(AB - 1) : 4'(NB - 1);
   assign bcnt_last = (bcnt == bcnt_lim);

   assign bus.o_p_we    = cmd_we;
   assign bus.o_p_addr  = addr;
   assign bus.o_p_wdata = wdata;
   assign o_busy        = !(state == S_IDLE || state == S_RST);

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_RST;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx       = state;
      set_code       = 1'b0;
      code_nx        = 8'h00;
      bus.o_rx_rdy   = 1'b0;
      bus.o_tx_vld   = 1'b0;
      bus.o_tx_data  = 8'h00;
      bus.o_p_sel    = 1'b0;
      bus.o_p_enable = 1'b0;
      bus.o_p_strb   = '0;
      case (state)
         S_RST: state_nx = S_IDLE;
         S_IDLE: begin
            bus.o_rx_rdy = 1'b1;
            if (bus.i_rx_vld) begin
               if (cmd_bad) begin
                  state_nx = S_STAT;
                  set_code = 1'b1;
                  code_nx  = 8'h02;
               end else begin
                  state_nx = S_ADDR;
               end
            end
         end
         S_ADDR, S_WDATA: begin
            bus.o_rx_rdy = 1'b1;
            if (bus.i_rx_vld) begin
               if (bcnt_last)
                  state_nx = (state == S_ADDR && cmd_we) ? S_WDATA : S_SETUP;
            end else if (rx_tmr == 32'(RX_TO_CYC - 1)) begin
               state_nx = S_STAT;
               set_code = 1'b1;
               code_nx  = 8'h04;
            end
         end
         S_SETUP: begin
            bus.o_p_sel  = 1'b1;
            bus.o_p_strb = {NB{cmd_we}};
            state_nx     = S_ACCESS;
         end
         S_ACCESS: begin
            bus.o_p_sel    = 1'b1;
            bus.o_p_enable = 1'b1;
            bus.o_p_strb   = {NB{cmd_we}};
            if (bus.i_p_ready) begin
               if (bus.i_p_slverr) begin
                  state_nx = S_STAT;
                  set_code = 1'b1;
                  code_nx  = 8'h03;
               end else if (!cmd_we) begin
                  state_nx = S_RDTX;
               end else if (done + 5'd1 == nbeats) begin
                  state_nx = S_STAT;
                  set_code = 1'b1;
               end else begin
                  state_nx = S_WDATA;
               end
            end else if (prdy_tmr == 32'(PRDY_TO_CYC - 1)) begin
               state_nx = S_STAT;
               set_code = 1'b1;
               code_nx  = 8'h01;
            end
         end
         S_RDTX: begin
            bus.o_tx_vld  = 1'b1;
            bus.o_tx_data = rdata[DW-1 -: 8];
            if (bus.i_tx_rdy && bcnt_last) begin
               if (done == nbeats) begin
                  state_nx = S_STAT;
                  set_code = 1'b1;
               end else begin
                  state_nx = S_SETUP;
               end
            end
         end
         S_STAT: begin
            bus.o_tx_vld  = 1'b1;
            bus.o_tx_data = stat_hi ? {3'b000, done} : code;
            if (bus.i_tx_rdy && stat_hi) state_nx = S_IDLE;
         end
         default: state_nx = S_RST;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cmd_we   <= 1'b0;
         cmd_inc  <= 1'b0;
         nbeats   <= '0;
         done     <= '0;
         bcnt     <= '0;
         addr     <= '0;
         wdata    <= '0;
         rdata    <= '0;
         rx_tmr   <= '0;
         prdy_tmr <= '0;
         code     <= '0;
         stat_hi  <= 1'b0;
      end else begin
         if (set_code) code <= code_nx;
         // Idle timers restart whenever their state is left, so entry is always clean.
         rx_tmr   <= '0;
         prdy_tmr <= '0;
         case (state)
            S_IDLE: if (rx_fire) begin
               cmd_we  <= bus.i_rx_data[7];
               cmd_inc <= bus.i_rx_data[6];
               nbeats  <= {1'b0, bus.i_rx_data[3:0]} + 5'd1;
               done    <= '0;
               bcnt    <= '0;
               stat_hi <= 1'b0;
            end
            S_ADDR, S_WDATA: begin
               if (rx_fire) begin
                  if (state == S_ADDR) addr  <= (addr << 8) | AW'(bus.i_rx_data);
                  else                 wdata <= (wdata << 8) | DW'(bus.i_rx_data);
                  bcnt <= bcnt_last ? 4'd0 : bcnt + 4'd1;
               end else begin
                  rx_tmr <= rx_tmr + 32'd1;
               end
            end
            S_ACCESS: begin
               prdy_tmr <= prdy_tmr + 32'd1;
               if (bus.i_p_ready) begin
                  rdata <= bus.i_p_rdata;
                  if (!bus.i_p_slverr) begin
                     done <= done + 5'd1;
                     if (cmd_inc) addr <= addr + AW'(NB);
                  end
               end
            end
            S_RDTX: if (tx_fire) begin
               rdata <= rdata << 8;
               bcnt  <= bcnt_last ? 4'd0 : bcnt + 4'd1;
            end
            S_STAT: if (tx_fire) stat_hi <= !stat_hi;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_uart2apb_burst_ctrl.sv
// Directed bench for uart2apb_burst_ctrl: UART byte driver, combinational APB
// slave keyed on PADDR, and a negedge monitor logging TX bytes and APB beats.
module tb_uart2apb_burst_ctrl;
   localparam int AW = 16;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   always #5 clk = ~clk;

   uart2apb_burst_ctrl_if #(.AW(AW), .DW(DW)) bus();

   uart2apb_burst_ctrl #(
      .AW(AW), .DW(DW), .MAX_BURST(16), .RX_TO_CYC(40), .PRDY_TO_CYC(10)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus),
      .o_busy(busy)
   );

   // slave: read data selected by PADDR[4:2], optional hang and error address
   logic [31:0] rtbl [8] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'hA1B2C3D4,
                             32'h44444444, 32'h55555555, 32'h66666666, 32'h88888888};
   logic        hang, err_en;
   logic [15:0] err_addr;
   assign bus.i_p_ready  = bus.o_p_sel & bus.o_p_enable & !hang;
   assign bus.i_p_rdata  = rtbl[bus.o_p_addr[4:2]];
   assign bus.i_p_slverr = err_en & (bus.o_p_addr == err_addr);

   logic [7:0]  tx_q[$];
   logic [7:0]  exp_q[$];
   logic [15:0] log_addr[$];
   logic [31:0] log_wdata[$];
   logic [3:0]  log_strb[$];
   logic        log_we[$];
   int          setup_cyc, pen_cyc;
   int          n_chk = 0, n_err = 0;

   always @(negedge clk) begin
      if (bus.o_tx_vld && bus.i_tx_rdy) tx_q.push_back(bus.o_tx_data);
      if (bus.o_p_sel && !bus.o_p_enable) setup_cyc++;
      if (bus.o_p_sel && bus.o_p_enable) pen_cyc++;
      if (bus.o_p_sel && bus.o_p_enable && bus.i_p_ready) begin
         log_addr.push_back(bus.o_p_addr);
         log_wdata.push_back(bus.o_p_wdata);
         log_strb.push_back(bus.o_p_strb);
         log_we.push_back(bus.o_p_we);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      tx_q.delete(); exp_q.delete();
      log_addr.delete(); log_wdata.delete(); log_strb.delete(); log_we.delete();
      setup_cyc = 0; pen_cyc = 0;
   endtask

   // called and returns at posedge+1
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.i_rx_vld = 1'b1; bus.i_rx_data = b;
      @(negedge clk);
      while (!bus.o_rx_rdy && n < 200) begin @(negedge clk); n++; end
      chk("rx_accept", 64'(n < 200), 64'd1);
      @(posedge clk); #1;
      bus.i_rx_vld = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge clk);
      while (busy && n < 3000) begin @(negedge clk); n++; end
      chk(tag, 64'(n < 3000), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic chk_tx(input string tag);
      chk({tag, "_len"}, 64'(tx_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), tx_q[i], exp_q[i]);
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
   endtask

   initial begin
      int n, bad;
      rst = 1'b1; hang = 1'b0; err_en = 1'b0; err_addr = '0;
      bus.i_rx_vld = 1'b0; bus.i_rx_data = '0; bus.i_tx_rdy = 1'b1;
      clr();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rx_rdy", bus.o_rx_rdy, 0);
      chk("rst_psel", bus.o_p_sel, 0);
      chk("rst_pen", bus.o_p_enable, 0);
      chk("rst_tx_vld", bus.o_tx_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pwe", bus.o_p_we, 0);
      chk("rst_paddr", bus.o_p_addr, 0);
      chk("rst_strb", bus.o_p_strb, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); chk("rdy_lag", bus.o_rx_rdy, 0);
      @(negedge clk); chk("rdy_idle", bus.o_rx_rdy, 1);
      @(posedge clk); #1;

      // single write
      clr();
      foreach (rtbl[i]) ;
      send_byte(8'h80); send_byte(8'h12); send_byte(8'h34);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
      wait_idle("wr1_done");
      chk("wr1_beats", log_addr.size(), 1);
      if (log_addr.size() > 0) begin
         chk("wr1_addr", log_addr[0], 16'h1234);
         chk("wr1_data", log_wdata[0], 32'hDEADBEEF);
         chk("wr1_strb", log_strb[0], 4'hF);
         chk("wr1_we", log_we[0], 1);
      end
      chk("wr1_setup", setup_cyc, 1);
      exp_q = '{8'h00, 8'h01}; chk_tx("wr1_tx");

      // read burst with increment
      clr();
      send_byte(8'h42); send_byte(8'h01); send_byte(8'h00);
      wait_idle("rd3_done");
      chk("rd3_beats", log_addr.size(), 3);
      for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
         chk($sformatf("rd3_addr%0d", i), log_addr[i], 16'h0100 + 16'(4*i));
         chk($sformatf("rd3_strb%0d", i), log_strb[i], 0);
      end
      chk("rd3_setup", setup_cyc, 3);
      push_word(32'h11111111); push_word(32'h22222222); push_word(32'h33333333);
      exp_q.push_back(8'h00); exp_q.push_back(8'h03);
      chk_tx("rd3_tx");

      // address wrap
      clr();
      send_byte(8'h41); send_byte(8'hFF); send_byte(8'hFC);
      wait_idle("wrap_done");
      chk("wrap_beats", log_addr.size(), 2);
      if (log_addr.size() == 2) begin
         chk("wrap_a0", log_addr[0], 16'hFFFC);
         chk("wrap_a1", log_addr[1], 16'h0000);
      end
      push_word(32'h88888888); push_word(32'h11111111);
      exp_q.push_back(8'h00); exp_q.push_back(8'h02);
      chk_tx("wrap_tx");

      // PSLVERR on second beat of a 4-beat write
      clr();
      err_en = 1'b1; err_addr = 16'h0204;
      send_byte(8'hC3); send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
      wait_idle("err_done");
      err_en = 1'b0;
      chk("err_beats", log_addr.size(), 2);
      chk("err_setup", setup_cyc, 2);
      if (log_addr.size() == 2) begin
         chk("err_d0", log_wdata[0], 32'h01020304);
         chk("err_a1", log_addr[1], 16'h0204);
      end
      exp_q = '{8'h03, 8'h01}; chk_tx("err_tx");

      // PREADY timeout
      clr();
      hang = 1'b1;
      send_byte(8'h00); send_byte(8'h03); send_byte(8'h00);
      wait_idle("prdy_done");
      hang = 1'b0;
      chk("prdy_pen_cyc", pen_cyc, 10);
      chk("prdy_beats", log_addr.size(), 0);
      exp_q = '{8'h01, 8'h00}; chk_tx("prdy_tx");

      // bad command, then RX timeout on the next frame
      clr();
      send_byte(8'h30);
      wait_idle("bad_done");
      exp_q = '{8'h02, 8'h00}; chk_tx("bad_tx");
      clr();
      send_byte(8'h80); send_byte(8'h12);
      wait_idle("rxto_done");
      chk("rxto_setup", setup_cyc, 0);
      exp_q = '{8'h04, 8'h00}; chk_tx("rxto_tx");

      // TX backpressure during RDTX
      clr();
      bus.i_tx_rdy = 1'b0;
      send_byte(8'h00); send_byte(8'h05); send_byte(8'h0C);
      n = 0;
      @(negedge clk);
      while (!bus.o_tx_vld && n < 200) begin @(negedge clk); n++; end
      chk("bp_vld", bus.o_tx_vld, 1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.o_tx_data !== 8'hA1 || bus.o_p_sel !== 1'b0 || bus.o_tx_vld !== 1'b1) bad++;
      end
      chk("bp_hold", bad, 0);
      chk("bp_no_tx", tx_q.size(), 0);
      bus.i_tx_rdy = 1'b1;
      wait_idle("bp_done");
      push_word(32'hA1B2C3D4); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
      chk_tx("bp_tx");

      // reset pulse during ACCESS
      clr();
      hang = 1'b1;
      send_byte(8'h00); send_byte(8'h06); send_byte(8'h00);
      n = 0;
      @(negedge clk);
      while (!bus.o_p_enable && n < 200) begin @(negedge clk); n++; end
      chk("rsta_pen", bus.o_p_enable, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk("rsta_psel", bus.o_p_sel, 0);
      chk("rsta_pen0", bus.o_p_enable, 0);
      hang = 1'b0;
      tx_q.delete();
      repeat (20) @(posedge clk);
      #1;
      chk("rsta_no_trl", tx_q.size(), 0);
      chk("rsta_busy", busy, 0);
      clr();
      send_byte(8'h80); send_byte(8'h00); send_byte(8'h10);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      wait_idle("rsta_done");
      chk("rsta_beats", log_addr.size(), 1);
      if (log_addr.size() > 0) begin
         chk("rsta_addr", log_addr[0], 16'h0010);
         chk("rsta_data", log_wdata[0], 32'h11223344);
      end
      exp_q = '{8'h00, 8'h01}; chk_tx("rsta_tx");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
